cond_unit_ext: RTL and testbench

Parametrised condition unit for the multicycle ARM core. It holds the NZCV flag register with per-group write enables and evaluates NCH 4-bit condition fields in parallel against the stored flags. It registers the results for the controller's later states and provides a Thumb-2 IT-block sequencer that overrides the condition on channel 0. It sits between the ALU flag outputs and the main controller FSM.

---
 rtl/cond_unit_ext.sv | 118 +++++++++++
 tb/tb_cond_unit_ext.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_ext.sv
// rtl/cond_unit_ext.sv - NZCV flag register, parallel condition evaluation and IT-block sequencer
module cond_unit_ext #(
  parameter int NCH   = 2,
  parameter bit IT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4*NCH-1:0] Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             cond_ld,
  input  logic             it_start,
  input  logic [3:0]       it_firstcond,
  input  logic [3:0]       it_mask,
  input  logic             it_adv,
  output logic [3:0]       Flags,
  output logic [NCH-1:0]   CondEx,
  output logic [NCH-1:0]   CondUndef,
  output logic [NCH-1:0]   CondExReg,
  output logic             it_active,
  output logic [3:0]       it_cond
);

  logic [3:0]     flags_q, flags_d;
  logic [NCH-1:0] cond_ex_q, cond_ex_d;
  logic [7:0]     itstate_q, itstate_d;
  logic [3:0]     eff_cond [NCH];

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ge;
    logic res;
    {n, z, cf, v} = f;
    ge = (n == v);
    case (c)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = cf;
      4'b0011: res = ~cf;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = cf & ~z;
      4'b1001: res = ~(cf & ~z);
      4'b1010: res = ge;
      4'b1011: res = ~ge;
      4'b1100: res = ~z & ge;
      4'b1101: res = ~(~z & ge);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign it_active = (itstate_q[3:0] != 4'b0000);
  assign it_cond   = it_active ? itstate_q[7:4] : 4'b0000;

  // Only channel 0 is overridden by the IT sequencer.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      eff_cond[i] = Cond[4*i +: 4];
    end
    if (it_active) begin
      eff_cond[0] = it_cond;
    end
  end

  always_comb begin
    CondEx    = '0;
    CondUndef = '0;
    for (int i = 0; i < NCH; i++) begin
      CondEx[i]    = cond_eval(eff_cond[i], flags_q);
      CondUndef[i] = (eff_cond[i] == 4'b1111);
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] && CondEx[0]) flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] && CondEx[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  assign cond_ex_d = cond_ld ? CondEx : cond_ex_q;

  // it_start takes priority; advancing shifts cond[0] along with the mask.
  always_comb begin
    itstate_d = itstate_q;
    if (IT_EN) begin
      if (it_start && (it_mask != 4'b0000)) begin
        itstate_d = {it_firstcond, it_mask};
      end else if (it_adv && it_active) begin
        if (itstate_q[2:0] == 3'b000) begin
          itstate_d = 8'h00;
        end else begin
          itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
        end
      end
    end else begin
      itstate_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= '0;
      itstate_q <= 8'h00;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
      itstate_q <= itstate_d;
    end
  end

  assign Flags     = flags_q;
  assign CondExReg = cond_ex_q;

endmodule

// File: tb/tb_cond_unit_ext.sv
// tb/tb_cond_unit_ext.sv - directed self-checking bench for cond_unit_ext
module tb_cond_unit_ext;

  logic       clk;
  logic       reset;
  logic [7:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       cond_ld;
  logic       it_start;
  logic [3:0] it_firstcond;
  logic [3:0] it_mask;
  logic       it_adv;
  logic [3:0] Flags;
  logic [1:0] CondEx;
  logic [1:0] CondUndef;
  logic [1:0] CondExReg;
  logic       it_active;
  logic [3:0] it_cond;

  int n_cmp = 0;
  int n_bad = 0;

  cond_unit_ext #(.NCH(2), .IT_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .Cond         (Cond),
    .ALUFlags     (ALUFlags),
    .FlagW        (FlagW),
    .cond_ld      (cond_ld),
    .it_start     (it_start),
    .it_firstcond (it_firstcond),
    .it_mask      (it_mask),
    .it_adv       (it_adv),
    .Flags        (Flags),
    .CondEx       (CondEx),
    .CondUndef    (CondUndef),
    .CondExReg    (CondExReg),
    .it_active    (it_active),
    .it_cond      (it_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Cond = 8'h00; ALUFlags = 4'h0; FlagW = 2'b00; cond_ld = 1'b0;
    it_start = 1'b0; it_firstcond = 4'h0; it_mask = 4'h0; it_adv = 1'b0;
    tick; tick;
    check("rst_flags", {4'h0, Flags}, 8'h00);
    check("rst_cereg", {6'h0, CondExReg}, 8'h00);
    check("rst_itact", {7'h0, it_active}, 8'h00);
    check("rst_itcond", {4'h0, it_cond}, 8'h00);
    reset = 1'b1;

    Cond = {4'b1110, 4'b0000}; #1;
    check("al_eq", {6'h0, CondEx}, 8'h02);
    check("undef0", {6'h0, CondUndef}, 8'h00);
    Cond = {4'b1010, 4'b1001}; #1;
    check("ge_ls_rst", {6'h0, CondEx}, 8'h03);

    // full write, then NE-gated write blocked
    Cond = {4'b1110, 4'b1110}; ALUFlags = 4'b0100; FlagW = 2'b11;
    tick;
    FlagW = 2'b00; Cond = 8'h00; #1;
    check("flags_0100", {4'h0, Flags}, 8'h04);
    check("eq_both", {6'h0, CondEx}, 8'h03);
    Cond = {4'b1110, 4'b0001}; ALUFlags = 4'b1011; FlagW = 2'b10; #1;
    check("ne_false", {6'h0, CondEx}, 8'h02);
    tick;
    check("gated_hold", {4'h0, Flags}, 8'h04);

    // same-cycle CondEx sees old flags
    Cond = {4'b0000, 4'b1110}; ALUFlags = 4'b0000; FlagW = 2'b11; #1;
    check("no_fwd", {6'h0, CondEx}, 8'h03);
    tick;
    check("flags_0000", {4'h0, Flags}, 8'h00);

    // partial writes, groups independent
    Cond = {4'b1110, 4'b1110}; ALUFlags = 4'b1111; FlagW = 2'b01;
    tick;
    FlagW = 2'b00;
    check("flags_0011", {4'h0, Flags}, 8'h03);
    Cond = {4'b1010, 4'b1000}; #1;
    check("hi1_ge0", {6'h0, CondEx}, 8'h01);
    Cond = {4'b1011, 4'b1110}; #1;
    check("lt1", {6'h0, CondEx}, 8'h03);
    ALUFlags = 4'b1000; FlagW = 2'b10;
    tick;
    FlagW = 2'b00;
    check("flags_1011", {4'h0, Flags}, 8'h0b);

    // ITE EQ with Z=1
    Cond = {4'b1110, 4'b1110}; ALUFlags = 4'b0100; FlagW = 2'b11;
    tick;
    FlagW = 2'b00;
    it_start = 1'b1; it_firstcond = 4'b0000; it_mask = 4'b1100;
    tick;
    it_start = 1'b0; Cond = {4'b1110, 4'b0001}; #1;
    check("ite_act", {7'h0, it_active}, 8'h01);
    check("ite_c0", {4'h0, it_cond}, 8'h00);
    check("ite_ex0", {6'h0, CondEx}, 8'h03);
    it_adv = 1'b1;
    tick;
    it_adv = 1'b0;
    check("ite_c1", {4'h0, it_cond}, 8'h01);
    check("ite_ex1", {6'h0, CondEx}, 8'h02);
    it_adv = 1'b1;
    tick;
    it_adv = 1'b0;
    check("ite_done", {7'h0, it_active}, 8'h00);
    check("ite_done_c", {4'h0, it_cond}, 8'h00);
    check("ite_own", {6'h0, CondEx}, 8'h02);

    // start wins over adv; cond lsb shifts with the mask
    it_start = 1'b1; it_firstcond = 4'b1010; it_mask = 4'b1000;
    tick;
    check("it1_c", {4'h0, it_cond}, 8'h0a);
    it_firstcond = 4'b0101; it_mask = 4'b0100; it_adv = 1'b1;
    tick;
    it_start = 1'b0; it_adv = 1'b0;
    check("replace_c", {4'h0, it_cond}, 8'h05);
    it_adv = 1'b1;
    tick;
    it_adv = 1'b0;
    check("shift_c", {4'h0, it_cond}, 8'h04);
    check("shift_act", {7'h0, it_active}, 8'h01);
    it_adv = 1'b1;
    tick;
    it_adv = 1'b0;
    check("it2_done", {7'h0, it_active}, 8'h00);

    // zero mask ignored, adv while inactive no effect
    it_start = 1'b1; it_firstcond = 4'b0011; it_mask = 4'b0000;
    tick;
    it_start = 1'b0;
    check("mask0_idle", {7'h0, it_active}, 8'h00);
    it_adv = 1'b1;
    tick;
    it_adv = 1'b0;
    check("adv_idle", {7'h0, it_active}, 8'h00);
    it_start = 1'b1; it_firstcond = 4'b1100; it_mask = 4'b1000;
    tick;
    it_firstcond = 4'b0000; it_mask = 4'b0000;
    tick;
    it_start = 1'b0;
    check("mask0_act", {4'h0, it_cond}, 8'h0c);

    // async reset mid-block
    reset = 1'b0; #1;
    check("rst_it", {7'h0, it_active}, 8'h00);
    check("rst_fl", {4'h0, Flags}, 8'h00);
    tick;
    reset = 1'b1;

    // undefined cond and CondExReg load/hold
    Cond = {4'b1111, 4'b1110}; #1;
    check("undef_ex", {6'h0, CondEx}, 8'h01);
    check("undef_u", {6'h0, CondUndef}, 8'h02);
    cond_ld = 1'b1;
    tick;
    cond_ld = 1'b0;
    check("cereg_ld", {6'h0, CondExReg}, 8'h01);
    ALUFlags = 4'b0100; FlagW = 2'b11;
    tick;
    FlagW = 2'b00; Cond = {4'b1110, 4'b0001}; #1;
    check("ce_new", {6'h0, CondEx}, 8'h02);
    tick;
    check("cereg_hold", {6'h0, CondExReg}, 8'h01);
    Cond = {4'b1110, 4'b1111}; #1;
    check("undef0_u", {6'h0, CondUndef}, 8'h01);
    check("undef0_ex", {6'h0, CondEx}, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
